// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multicycle multiply/divide unit.
//   mdu_state_t       - FSM state encoding (IDLE, MULT, DIV, DONE)
//   MDU_DEFAULT_WIDTH - default operand / HI / LO width
//   MDU_CNT_W         - iteration-counter width for the default width
//   mdu_cnt_width()   - iteration-counter width for an arbitrary width
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_DEFAULT_WIDTH = 32;
  localparam int MDU_CNT_W         = $clog2(MDU_DEFAULT_WIDTH) + 1;

  // Counter must hold values up to WIDTH-1 with one bit of headroom.
  function automatic int mdu_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control unit (master)
// and the multiply/divide unit (slave).
//   start_mult, start_div, is_signed, op_a, op_b : requests from control
//   busy, done, div_zero, hi, lo                 : status and results
// Optional macro MDU_HILO_WRITE_EN adds hilo_wr_hi, hilo_wr_lo, hilo_wdata
// (MTHI/MTLO write port).
interface mult_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DEFAULT_WIDTH
);

  logic             start_mult;
  logic             start_div;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MDU_HILO_WRITE_EN
  logic             hilo_wr_hi;
  logic             hilo_wr_lo;
  logic [WIDTH-1:0] hilo_wdata;

  modport master (
    output start_mult, start_div, is_signed, op_a, op_b,
    output hilo_wr_hi, hilo_wr_lo, hilo_wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, is_signed, op_a, op_b,
    input  hilo_wr_hi, hilo_wr_lo, hilo_wdata,
    output busy, done, div_zero, hi, lo
  );
`else
  modport master (
    output start_mult, start_div, is_signed, op_a, op_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, is_signed, op_a, op_b,
    output busy, done, div_zero, hi, lo
  );
`endif

endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: one combinational restoring-division step.
//   rem_in   - partial remainder (always < divisor)
//   quot_in  - dividend bits still to shift in (MSB first) / quotient so far
//   divisor  - divisor magnitude, non-zero
//   rem_out  - next partial remainder
//   quot_out - quot_in shifted left with the new quotient bit in bit 0
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract; a set MSB of diff means the subtraction went negative,
  // so the shifted remainder is restored and the quotient bit is zero.
  always_comb begin
    shifted = {rem_in, quot_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_out  = shifted[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out  = diff[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle integer multiply/divide unit with HI/LO registers.
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - mult_div_unit_if.slave: start_mult/start_div/is_signed/op_a/op_b
//           in; busy/done/div_zero/hi/lo out.
// Multiply: shift-add on magnitudes, WIDTH cycles, sign fixed at commit.
// Divide: restoring, WIDTH cycles, quotient truncates toward zero and the
// remainder follows the dividend sign. Divide by zero commits immediately
// with div_zero and leaves HI/LO untouched.
// Optional macro MDU_HILO_WRITE_EN enables the MTHI/MTLO write port (IDLE only).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = mdu_cnt_width(WIDTH);

  mdu_state_t         state;
  mdu_state_t         next_state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;        // multiplicand (MULT) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0] mul_acc;     // {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quot;
  logic               neg_q;       // negate product / quotient at commit
  logic               neg_r;       // negate remainder at commit
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               div_zero_reg;

  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quot_next;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Add multiplicand into the upper half when the current multiplier bit is
  // set, then shift the whole accumulator right (carry included).
  assign mul_sum  = {1'b0, mul_acc[2*WIDTH-1:WIDTH]} +
                    (mul_acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, mul_acc[WIDTH-1:1]};
  assign prod_fix = neg_q ? -mul_next : mul_next;

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem_in   (div_rem),
    .quot_in  (div_quot),
    .divisor  (opnd),
    .rem_out  (div_rem_next),
    .quot_out (div_quot_next)
  );

  assign quot_fix = neg_q ? -div_quot_next : div_quot_next;
  assign rem_fix  = neg_r ? -div_rem_next  : div_rem_next;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; multiply wins when both starts are high.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start_mult) begin
          next_state = MULT;
        end else if (bus.start_div) begin
          next_state = (bus.op_b == '0) ? DONE : DIV;
        end else begin
          next_state = IDLE;
        end
      end
      MULT:    next_state = last_iter ? DONE : MULT;
      DIV:     next_state = last_iter ? DONE : DIV;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, commit and HI/LO write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      opnd         <= '0;
      mul_acc      <= '0;
      div_rem      <= '0;
      div_quot     <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MDU_HILO_WRITE_EN
          if (bus.hilo_wr_hi) hi_reg <= bus.hilo_wdata;
          if (bus.hilo_wr_lo) lo_reg <= bus.hilo_wdata;
`endif
          cnt <= '0;
          if (bus.start_mult) begin
            opnd    <= magnitude(bus.op_a, bus.is_signed);
            mul_acc <= {{WIDTH{1'b0}}, magnitude(bus.op_b, bus.is_signed)};
            neg_q   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          end else if (bus.start_div) begin
            if (bus.op_b == '0) begin
              done_reg     <= 1'b1;
              div_zero_reg <= 1'b1;
            end else begin
              opnd     <= magnitude(bus.op_b, bus.is_signed);
              div_rem  <= '0;
              div_quot <= magnitude(bus.op_a, bus.is_signed);
              neg_q    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
              neg_r    <= bus.is_signed & bus.op_a[WIDTH-1];
            end
          end
        end
        MULT: begin
          mul_acc <= mul_next;
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) begin
            {hi_reg, lo_reg} <= prod_fix;
            done_reg         <= 1'b1;
          end
        end
        DIV: begin
          div_rem  <= div_rem_next;
          div_quot <= div_quot_next;
          cnt      <= cnt + CNT_W'(1);
          if (last_iter) begin
            lo_reg   <= quot_fix;
            hi_reg   <= rem_fix;
            done_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule
